// File: rtl/safecrack_lock_n.sv
// N-button combination-lock controller with runtime code, ms-configured holds.
// Optional consecutive-failure lockout enabled by defining SAFECRACK_LOCKOUT_EN.
module safecrack_lock_n #(
  parameter int unsigned N_BTN     = 3,
  parameter int unsigned CODE_LEN  = 3,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ERR_MS    = 3000,
  parameter int unsigned OK_MS     = 5000,
  parameter int unsigned MAX_FAILS = 3,
  parameter int unsigned LOCK_MS   = 30000,
  localparam int unsigned DW       = (N_BTN > 2) ? $clog2(N_BTN) : 1,
  localparam int unsigned FW       = $clog2(MAX_FAILS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_n,
  input  logic [CODE_LEN*DW-1:0]   code_i,
  output logic [CODE_LEN-1:0]      progress,
  output logic                     led_red,
  output logic                     unlocked,
  output logic                     locked_out,
  output logic [FW-1:0]            fail_cnt
);

  localparam int unsigned MS_CYC  = CLK_HZ / 1000;
  localparam int unsigned ERR_CYC = ERR_MS * MS_CYC;
  localparam int unsigned OK_CYC  = OK_MS * MS_CYC;
`ifdef SAFECRACK_LOCKOUT_EN
  localparam int unsigned LOCK_CYC = LOCK_MS * MS_CYC;
  localparam int unsigned MAX_EO   = (ERR_CYC > OK_CYC) ? ERR_CYC : OK_CYC;
  localparam int unsigned MAX_HOLD = (LOCK_CYC > MAX_EO) ? LOCK_CYC : MAX_EO;
`else
  localparam int unsigned MAX_HOLD = (ERR_CYC > OK_CYC) ? ERR_CYC : OK_CYC;
`endif
  localparam int unsigned TW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned PW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

  // Elaboration-time sanity on parameters, including 32-bit hold overflow.
  if (N_BTN < 2 || CODE_LEN < 1 || MAX_FAILS < 1 || ERR_CYC == 0 || OK_CYC == 0 ||
      64'(ERR_MS) * 64'(MS_CYC) > 64'hFFFF_FFFF ||
      64'(OK_MS) * 64'(MS_CYC) > 64'hFFFF_FFFF ||
      64'(LOCK_MS) * 64'(MS_CYC) > 64'hFFFF_FFFF) begin : g_bad_param
    $error("safecrack_lock_n: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_ERROR   = 2'd1,
    ST_SUCCESS = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t                    r_state;
  logic [PW-1:0]             r_pos;
  logic [TW-1:0]             r_timer;
  logic [FW-1:0]             r_fail;
  logic [N_BTN-1:0]          r_btn_prev;
  logic [CODE_LEN*DW-1:0]    r_code_q;

  logic [N_BTN-1:0]          w_btn_pos;
  logic [N_BTN-1:0]          w_edge;
  logic                      w_any_edge;
  logic [DW-1:0]             w_exp_digit;
  logic [N_BTN-1:0]          w_exp_onehot;
  logic                      w_hit;
  logic                      w_last;
  logic [FW-1:0]             w_fail_inc;
  logic [CODE_LEN-1:0]       w_prog_dec;

  assign w_btn_pos  = ~btn_n;
  assign w_edge     = w_btn_pos & ~r_btn_prev;
  assign w_any_edge = |w_edge;
  assign w_last     = (r_pos == PW'(CODE_LEN - 1));
  assign w_fail_inc = (r_fail == FW'(MAX_FAILS)) ? r_fail : r_fail + FW'(1);

  // Digit 0 tracks code_i live; later digits come from the snapshot.
  always_comb begin
    w_exp_digit = code_i[DW-1:0];
    for (int k = 0; k < CODE_LEN; k++) begin
      if (r_pos == PW'(k)) w_exp_digit = r_code_q[k*DW +: DW];
    end
    if (r_pos == '0) w_exp_digit = code_i[DW-1:0];
  end

  // Out-of-range digit indices decode to zero, so any edge then fails.
  always_comb begin
    w_exp_onehot = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_exp_onehot[i] = (w_exp_digit == DW'(i));
    end
  end

  assign w_hit = (w_edge == w_exp_onehot);

  always_comb begin
    w_prog_dec = '0;
    if (r_state == ST_SUCCESS) begin
      w_prog_dec = '1;
    end else if (r_state == ST_ENTRY) begin
      for (int i = 0; i < CODE_LEN; i++) begin
        w_prog_dec[i] = (r_pos > PW'(i));
      end
    end
  end

  // State machine; outputs are registered decodes of the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ENTRY;
      r_pos      <= '0;
      r_timer    <= '0;
      r_fail     <= '0;
      r_btn_prev <= '0;
      r_code_q   <= '0;
      progress   <= '0;
      led_red    <= 1'b0;
      unlocked   <= 1'b0;
      fail_cnt   <= '0;
`ifdef SAFECRACK_LOCKOUT_EN
      locked_out <= 1'b0;
`endif
    end else begin
      r_btn_prev <= w_btn_pos;
      progress   <= w_prog_dec;
      led_red    <= (r_state == ST_ERROR) || (r_state == ST_LOCKOUT);
      unlocked   <= (r_state == ST_SUCCESS);
      fail_cnt   <= r_fail;
`ifdef SAFECRACK_LOCKOUT_EN
      locked_out <= (r_state == ST_LOCKOUT);
`endif
      case (r_state)
        ST_ENTRY: begin
          if (r_pos == '0) r_code_q <= code_i;
          if (w_any_edge) begin
            if (w_hit) begin
              if (w_last) begin
                r_state <= ST_SUCCESS;
                r_pos   <= '0;
                r_fail  <= '0;
                r_timer <= TW'(OK_CYC - 1);
              end else begin
                r_pos <= r_pos + PW'(1);
              end
            end else begin
              r_pos  <= '0;
              r_fail <= w_fail_inc;
`ifdef SAFECRACK_LOCKOUT_EN
              if (w_fail_inc == FW'(MAX_FAILS)) begin
                r_state <= ST_LOCKOUT;
                r_timer <= TW'(LOCK_CYC - 1);
              end else begin
                r_state <= ST_ERROR;
                r_timer <= TW'(ERR_CYC - 1);
              end
`else
              r_state <= ST_ERROR;
              r_timer <= TW'(ERR_CYC - 1);
`endif
            end
          end
        end
        default: begin
          // Hold states ignore buttons and count down to ENTRY.
          if (r_timer == '0) begin
            r_state <= ST_ENTRY;
            r_pos   <= '0;
`ifdef SAFECRACK_LOCKOUT_EN
            if (r_state == ST_LOCKOUT) r_fail <= '0;
`endif
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
      endcase
    end
  end

`ifndef SAFECRACK_LOCKOUT_EN
  assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_safecrack_lock_n.sv
// Directed bench for safecrack_lock_n: 4 buttons, code 0,2,1,3, 1 ms = 1 cycle.
// Expectations follow SAFECRACK_LOCKOUT_EN when defined.
module tb_safecrack_lock_n;

  localparam logic [3:0] ID  = 4'b1111;
  localparam logic [3:0] P0  = 4'b1110;
  localparam logic [3:0] P1  = 4'b1101;
  localparam logic [3:0] P2  = 4'b1011;
  localparam logic [3:0] P3  = 4'b0111;
  localparam logic [3:0] P02 = 4'b1010;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [7:0] code_i;
  logic [3:0] progress;
  logic       led_red;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  safecrack_lock_n #(
    .N_BTN(4), .CODE_LEN(4), .CLK_HZ(1000), .ERR_MS(3), .OK_MS(5),
    .MAX_FAILS(3), .LOCK_MS(10)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .code_i(code_i),
    .progress(progress), .led_red(led_red), .unlocked(unlocked),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] prog;
    logic       red;
    logic       unl;
    logic [1:0] fcnt;
  } vec_t;

  vec_t vecs[40];

  function automatic vec_t mk(input logic r, input logic [3:0] b, input logic [3:0] p,
                              input logic red, input logic unl, input logic [1:0] f);
    vec_t v;
    v.rst = r; v.btn = b; v.prog = p; v.red = red; v.unl = unl; v.fcnt = f;
    return v;
  endfunction

  // Drive inputs, then sample 1 time unit after the next rising edge.
  task automatic cyc(input logic [3:0] b, input logic r);
    btn_n = b;
    rst   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] outv();
    return {progress, led_red, unlocked, locked_out, fail_cnt};
  endfunction

  // Press 0,2,1 with idle gaps, then 3; the caller observes the SUCCESS hold.
  task automatic enter_code();
    cyc(P0, 1'b0); cyc(ID, 1'b0);
    cyc(P2, 1'b0); cyc(ID, 1'b0);
    cyc(P1, 1'b0); cyc(ID, 1'b0);
    cyc(P3, 1'b0);
  endtask

  task automatic run_count(input int ncyc, input int press_at, input logic [3:0] pbtn,
                           output int c_unl, output int c_red, output int c_lo);
    c_unl = 0; c_red = 0; c_lo = 0;
    for (int k = 0; k < ncyc; k++) begin
      cyc((k == press_at) ? pbtn : ID, 1'b0);
      if (unlocked === 1'b1) c_unl++;
      if (led_red === 1'b1) c_red++;
      if (locked_out === 1'b1) c_lo++;
    end
  endtask

  int cu, cr, cl;

  initial begin
    code_i = {2'd3, 2'd1, 2'd2, 2'd0};
    btn_n  = ID;
    rst    = 1'b1;

    // Each row's outputs reflect the state reached by the previous row's edge.
    vecs[0]  = mk(1, ID,  4'b0000, 0, 0, 0);
    vecs[1]  = mk(0, ID,  4'b0000, 0, 0, 0);
    vecs[2]  = mk(0, P0,  4'b0000, 0, 0, 0);
    vecs[3]  = mk(0, ID,  4'b0001, 0, 0, 0);
    vecs[4]  = mk(0, P2,  4'b0001, 0, 0, 0);
    vecs[5]  = mk(0, ID,  4'b0011, 0, 0, 0);
    vecs[6]  = mk(0, P1,  4'b0011, 0, 0, 0);
    vecs[7]  = mk(0, ID,  4'b0111, 0, 0, 0);
    vecs[8]  = mk(0, P3,  4'b0111, 0, 0, 0);
    vecs[9]  = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[10] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[11] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[12] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[13] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[14] = mk(0, ID,  4'b0000, 0, 0, 0);
    vecs[15] = mk(0, P0,  4'b0000, 0, 0, 0);
    vecs[16] = mk(0, ID,  4'b0001, 0, 0, 0);
    vecs[17] = mk(0, P1,  4'b0001, 0, 0, 0);
    vecs[18] = mk(0, ID,  4'b0000, 1, 0, 1);
    vecs[19] = mk(0, ID,  4'b0000, 1, 0, 1);
    vecs[20] = mk(0, ID,  4'b0000, 1, 0, 1);
    vecs[21] = mk(0, ID,  4'b0000, 0, 0, 1);
    vecs[22] = mk(0, P0,  4'b0000, 0, 0, 1);
    vecs[23] = mk(0, ID,  4'b0001, 0, 0, 1);
    vecs[24] = mk(0, P2,  4'b0001, 0, 0, 1);
    vecs[25] = mk(0, ID,  4'b0011, 0, 0, 1);
    vecs[26] = mk(0, P1,  4'b0011, 0, 0, 1);
    vecs[27] = mk(0, ID,  4'b0111, 0, 0, 1);
    vecs[28] = mk(0, P3,  4'b0111, 0, 0, 1);
    vecs[29] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[30] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[31] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[32] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[33] = mk(0, ID,  4'b1111, 0, 1, 0);
    vecs[34] = mk(0, ID,  4'b0000, 0, 0, 0);
    vecs[35] = mk(0, P02, 4'b0000, 0, 0, 0);
    vecs[36] = mk(0, ID,  4'b0000, 1, 0, 1);
    vecs[37] = mk(0, ID,  4'b0000, 1, 0, 1);
    vecs[38] = mk(0, ID,  4'b0000, 1, 0, 1);
    vecs[39] = mk(0, ID,  4'b0000, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      cyc(vecs[i].btn, vecs[i].rst);
      chk($sformatf("vec%0d {prog,red,unl,lo,fail}", i), 32'(outv()),
          32'({vecs[i].prog, vecs[i].red, vecs[i].unl, 1'b0, vecs[i].fcnt}));
    end

    // Held btn0 across an ERROR hold: no edge once ENTRY resumes.
    cyc(P0, 1'b0);
    cyc(4'b1100, 1'b0);
    cr = 0;
    for (int k = 0; k < 5; k++) begin
      cyc(P0, 1'b0);
      if (led_red === 1'b1) cr++;
    end
    chk("held_err_red_cycles", 32'(cr), 32'd3);
    chk("held_progress_while_held", 32'(progress), 32'h0);
    cyc(ID, 1'b0);
    cyc(ID, 1'b0);
    chk("held_progress_after", 32'(progress), 32'h0);
    chk("held_fail_cnt", 32'(fail_cnt), 32'd2);

    // Press btn3 during SUCCESS: ignored, hold still 5 cycles.
    enter_code();
    run_count(10, 1, P3, cu, cr, cl);
    chk("succ_press_unl_cycles", 32'(cu), 32'd5);
    chk("succ_press_red_cycles", 32'(cr), 32'd0);
    chk("succ_after_outputs", 32'(outv()), 32'h0);

    // Reset at pos=2, then immediate correct entry.
    cyc(ID, 1'b1);
    chk("rst_a_outputs", 32'(outv()), 32'h0);
    cyc(P0, 1'b0); cyc(ID, 1'b0); cyc(P2, 1'b0); cyc(ID, 1'b0);
    chk("pos2_progress", 32'(progress), 32'h3);
    cyc(ID, 1'b1);
    chk("rst_pos2_outputs", 32'(outv()), 32'h0);
    enter_code();
    run_count(10, -1, ID, cu, cr, cl);
    chk("after_rst_pos2_unl_cycles", 32'(cu), 32'd5);

    // Reset mid-SUCCESS.
    enter_code();
    cyc(ID, 1'b0);
    chk("mid_succ_unlocked", 32'(unlocked), 32'd1);
    cyc(ID, 1'b0);
    cyc(ID, 1'b1);
    chk("rst_succ_outputs", 32'(outv()), 32'h0);
    cyc(ID, 1'b0);
    chk("rst_succ_state_entry", 32'(outv()), 32'h0);
    enter_code();
    run_count(10, -1, ID, cu, cr, cl);
    chk("after_rst_succ_unl_cycles", 32'(cu), 32'd5);

    // Consecutive wrong first digits.
    cyc(ID, 1'b1);
    cyc(P1, 1'b0);
    run_count(8, -1, ID, cu, cr, cl);
    chk("fail1_red_cycles", 32'(cr), 32'd3);
    chk("fail1_fail_cnt", 32'(fail_cnt), 32'd1);
    cyc(P1, 1'b0);
    run_count(8, -1, ID, cu, cr, cl);
    chk("fail2_red_cycles", 32'(cr), 32'd3);
    chk("fail2_fail_cnt", 32'(fail_cnt), 32'd2);
    cyc(P1, 1'b0);
`ifdef SAFECRACK_LOCKOUT_EN
    run_count(14, -1, ID, cu, cr, cl);
    chk("lockout_lo_cycles", 32'(cl), 32'd10);
    chk("lockout_red_cycles", 32'(cr), 32'd10);
    chk("lockout_fail_cnt_cleared", 32'(fail_cnt), 32'd0);
`else
    run_count(8, -1, ID, cu, cr, cl);
    chk("fail3_red_cycles", 32'(cr), 32'd3);
    chk("fail3_lo_cycles", 32'(cl), 32'd0);
    chk("fail3_fail_cnt", 32'(fail_cnt), 32'd3);
    cyc(P1, 1'b0);
    run_count(8, -1, ID, cu, cr, cl);
    chk("fail4_red_cycles", 32'(cr), 32'd3);
    chk("fail4_fail_cnt_sat", 32'(fail_cnt), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
